// File: rtl/bcd_counter_ctrl.sv
// Sequencer for a cascade of DIGITS decade counters.
// It runs a start/pause/clear state machine and a tick prescaler, and it
// drives the per-digit cascade enables. It stops with a one-cycle done pulse
// when the BCD count reaches the target that was latched at start.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | cleared, count 0, waiting for start
// S_RUN    | prescaler running, count advances on each tick
// S_PAUSED | count and prescaler frozen, start resumes
// S_DONE   | target reached, count holds, start restarts from 0
module bcd_counter_ctrl #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   target,
  output logic [DIGITS-1:0]     digit_en,
  output logic [4*DIGITS-1:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [4*DIGITS-1:0]  count_q, count_d;
  logic [4*DIGITS-1:0]  target_q, target_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 tgt_ok;
  logic                 tick;
  logic [4*DIGITS-1:0]  count_nxt;

  // A start is accepted only when every target digit is a legal BCD digit.
  always_comb begin
    tgt_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (target[4*i +: 4] > 4'd9) tgt_ok = 1'b0;
    end
  end

  // A pause in the tick cycle drops that tick.
  assign tick = (state_q == S_RUN) && (presc_q == PRESC_MAX) && !pause;

  // Ripple the cascade enables: a digit advances when every lower digit wraps.
  always_comb begin
    digit_en = '0;
    digit_en[0] = tick;
    for (int i = 1; i < DIGITS; i++) begin
      digit_en[i] = digit_en[i-1] && (count_q[4*(i-1) +: 4] == 4'd9);
    end
  end

  // Count value after the enabled digits advance, with 9 wrapping to 0.
  always_comb begin
    count_nxt = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_en[i]) begin
        count_nxt[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0
                                                          : count_q[4*i +: 4] + 4'd1;
      end
    end
  end

  // Next-state logic; clear overrides start, and start overrides pause.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    presc_d  = presc_q;
    target_d = target_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (tgt_ok) begin
              target_d = target;
              count_d  = '0;
              presc_d  = '0;
              state_d  = S_RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
            if (tick) begin
              count_d = count_nxt;
              if (count_nxt == target_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        S_PAUSED: begin
          if (start) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      presc_q  <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      target_q <= target_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == S_RUN) || (state_q == S_PAUSED);
  assign done  = done_q;
  assign err   = err_q;
  assign state = state_q;

endmodule
